// File: rtl/ksa_mp_addsub_seq.sv
// Multi-precision add/subtract sequencer. WORDS x 32-bit operands are streamed
// through one 32-bit Kogge-Stone adder, least-significant slice first, and the
// carry is chained in a register.
// Optional feature: define KSA_SEQ_OVF_EN to enable the signed-overflow flag.
// When it is not defined, out_ovf is tied to 0.

// 32-bit Kogge-Stone adder with carry-in; s[32] is the carry-out
module UBPriKSA_31_0 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [32:0] s
);
  logic [31:0] p0, g0, g1, p1, g2, p2, g3, p3, g4, p4, g5;

  // Prefix tree; carry-in is folded into the bit-0 generate term
  always_comb begin
    p0 = x ^ y;
    g0 = x & y;
    g0[0] = (x[0] & y[0]) | (p0[0] & cin);
    g1 = g0 | (p0 & {g0[30:0], 1'b0});
    p1 = p0 & {p0[30:0], 1'b1};
    g2 = g1 | (p1 & {g1[29:0], 2'b0});
    p2 = p1 & {p1[29:0], 2'b11};
    g3 = g2 | (p2 & {g2[27:0], 4'b0});
    p3 = p2 & {p2[27:0], 4'hF};
    g4 = g3 | (p3 & {g3[23:0], 8'b0});
    p4 = p3 & {p3[23:0], 8'hFF};
    g5 = g4 | (p4 & {g4[15:0], 16'b0});
    s  = {g5[31], p0 ^ {g5[30:0], cin}};
  end
endmodule

module ksa_mp_addsub_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  busy
);
  localparam int unsigned W    = 32 * WORDS;
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [31:0]       x_c, y_c;
  logic [32:0]       s_c;
  logic              last_c;

  // Select the current operand slice; subtract inverts B
  always_comb begin
    x_c = '0;
    y_c = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (idx_q == IDXW'(k)) begin
        x_c = a_q[32*k +: 32];
        y_c = b_q[32*k +: 32] ^ {32{sub_q}};
      end
    end
  end

  assign last_c = (idx_q == IDXW'(WORDS - 1));

  UBPriKSA_31_0 u_core (
    .x   (x_c),
    .y   (y_c),
    .cin (carry_q),
    .s   (s_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_RUN;
          a_d        = in_a;
          b_d        = in_b;
          sub_d      = in_sub;
          carry_d    = in_sub;
          idx_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < int'(WORDS); k++) begin
          if (idx_q == IDXW'(k)) sum_d[32*k +: 32] = s_c[31:0];
        end
        carry_d = s_c[32];
        if (last_c) begin
          state_d     = ST_DONE;
          idx_d       = '0;
          cout_d      = s_c[32];
          out_valid_d = 1'b1;
        end else begin
          idx_d = IDXW'(idx_q + 1'b1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef KSA_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Two's-complement overflow of the top slice, captured on the final RUN edge
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ST_RUN && last_c)
      ovf_d = (x_c[31] == y_c[31]) && (s_c[31] != x_c[31]);
  end

  // Overflow flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
